intipi_seq: RTL and testbench

- PerInt master that shares the interrupt controller's CMDINTDST command among REQCOUNT requesters, typically PUs raising inter-processor interrupts.
- Arbitrates round-robin, issues the PIRWOP command word, and decodes the reply: target index on success, -2 busy, -1 invalid.
- Retries busy replies with a fixed back-off, then reports per-requester completion status.
- Sits between the PUs' IPI request lines and the interrupt controller's pi1 slave port.

---
 rtl/intipi_seq_if.sv | 14 +
 rtl/intipi_seq.sv | 121 ++++++++++++
 tb/tb_intipi_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/intipi_seq_if.sv
// intipi_seq_if: PerInt pi1 bus between the IPI sequencer (master) and the interrupt controller (slave).
interface intipi_seq_if #(
  parameter int ARCHBITSZ = 16,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
);
  logic [1:0]             pi1_op_o;
  logic [ADDRBITSZ-1:0]   pi1_addr_o;
  logic [ARCHBITSZ-1:0]   pi1_data_o;
  logic [ARCHBITSZ-1:0]   pi1_data_i;
  logic [ARCHBITSZ/8-1:0] pi1_sel_o;
  logic                   pi1_rdy_i;
  modport master (output pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o, input pi1_data_i, pi1_rdy_i);
  modport slave (input pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o, output pi1_data_i, pi1_rdy_i);
endinterface

// File: rtl/intipi_seq.sv
// intipi_seq: round-robin PerInt master issuing CMDINTDST IPIs with busy back-off/retry.
// Defining INTIPISEQ_BCAST_EN turns an all-ones dst into a broadcast to every other destination.
module intipi_seq #(
  parameter int ARCHBITSZ   = 16,
  parameter int REQCOUNT    = 2,
  parameter int INTDSTCOUNT = 2,
  parameter int INTCTRLADDR = 0,
  parameter int RETRYDELAY  = 8,
  parameter int MAXRETRY    = 15,
  localparam int DSTBITSZ   = INTDSTCOUNT > 1 ? $clog2(INTDSTCOUNT) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [REQCOUNT-1:0]          rqst_i,
  input  logic [REQCOUNT*DSTBITSZ-1:0] dst_i,
  output logic [REQCOUNT-1:0]          done_o,
  output logic                         ok_o,
  output logic                         busy_o,
  intipi_seq_if.master                 pi1
);
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
  localparam int GW = REQCOUNT > 1 ? $clog2(REQCOUNT) : 1;
  localparam int CW = MAXRETRY > 0 ? $clog2(MAXRETRY + 1) : 1;
  localparam int DW = $clog2(RETRYDELAY + 1);
`ifdef INTIPISEQ_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ISSUE, RESP, WAIT, DONE} state_t;
  state_t               state_q;
  logic [GW-1:0]        rr_q, g_q, gnt;
  logic [DSTBITSZ-1:0]  tgt_q, dsel, t0;
  logic [CW-1:0]        retry_q;
  logic [DW-1:0]        dly_q;
  logic [1:0]           op_q;
  logic [ARCHBITSZ-1:0] data_q;
  logic [REQCOUNT-1:0]  done_q;
  logic                 ok_q, bc_q, all_q, bc_d, r_ok, r_busy;
  int                   nt;
  // second pass overrides the wrap-around pick when a request exists at/after rr_q
  always_comb begin
    gnt = '0;
    for (int i = REQCOUNT - 1; i >= 0; i--) if (rqst_i[i]) gnt = GW'(i);
    for (int i = REQCOUNT - 1; i >= 0; i--) if (rqst_i[i] && i >= int'(rr_q)) gnt = GW'(i);
    dsel = '0;
    for (int i = 0; i < REQCOUNT; i++) if (gnt == GW'(i)) dsel = dst_i[i*DSTBITSZ +: DSTBITSZ];
    bc_d = BCAST && dsel == '1 && int'(gnt) < INTDSTCOUNT;
    t0 = bc_d ? DSTBITSZ'(gnt == '0) : dsel;
    r_ok = pi1.pi1_data_i == ARCHBITSZ'(tgt_q);
    r_busy = pi1.pi1_data_i == {{(ARCHBITSZ-1){1'b1}}, 1'b0};
    nt = int'(tgt_q) + 1;
    nt = nt == int'(g_q) ? nt + 1 : nt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      data_q  <= '0;
      done_q  <= '0;
      ok_q    <= 1'b0;
      rr_q    <= '0;
      retry_q <= '0;
      g_q     <= '0;
      tgt_q   <= '0;
      dly_q   <= '0;
      bc_q    <= 1'b0;
      all_q   <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: if (|rqst_i) begin
          g_q     <= gnt;
          rr_q    <= int'(gnt) == REQCOUNT - 1 ? '0 : gnt + 1'b1;
          tgt_q   <= t0;
          data_q  <= ARCHBITSZ'({t0, 2'b01});
          retry_q <= '0;
          bc_q    <= bc_d;
          all_q   <= 1'b1;
          op_q    <= 2'b11;
          state_q <= ISSUE;
        end
        ISSUE: if (pi1.pi1_rdy_i) begin
          op_q    <= 2'b00;
          state_q <= RESP;
        end
        RESP: if (r_busy && retry_q < CW'(MAXRETRY)) begin
          retry_q <= retry_q + 1'b1;
          dly_q   <= DW'(RETRYDELAY);
          state_q <= WAIT;
        end else if (bc_q && nt < INTDSTCOUNT) begin
          all_q   <= all_q & r_ok;
          tgt_q   <= DSTBITSZ'(nt);
          data_q  <= ARCHBITSZ'({DSTBITSZ'(nt), 2'b01});
          retry_q <= '0;
          op_q    <= 2'b11;
          state_q <= ISSUE;
        end else begin
          ok_q        <= all_q & r_ok;
          done_q[g_q] <= 1'b1;
          state_q     <= DONE;
        end
        WAIT: begin
          dly_q <= dly_q - 1'b1;
          if (dly_q == DW'(1)) begin
            op_q    <= 2'b11;
            state_q <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done_o         = done_q;
  assign ok_o           = ok_q;
  assign busy_o         = state_q != IDLE;
  assign pi1.pi1_op_o   = op_q;
  assign pi1.pi1_data_o = data_q;
  assign pi1.pi1_addr_o = ADDRBITSZ'(INTCTRLADDR);
  assign pi1.pi1_sel_o  = '1;
endmodule

// File: tb/tb_intipi_seq.sv
// tb_intipi_seq: vector table of single IPI transactions plus round-robin and reset-in-WAIT sequences.
module tb_intipi_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] rqst = '0;
  logic [3:0] dst = '0;
  logic [1:0] done;
  logic ok, busy;
  int total = 0, bad = 0, cyc = 0, n_acc = 0, base = 0, c = 0;
  logic [15:0] rep [8];
  int acc_t [64];
  logic [15:0] acc_d [64];
  typedef struct {
    logic [1:0] rq; logic [3:0] dst; logic [15:0] r0, r1, r2; int stall;
    logic [1:0] edone; logic eok; int eiss; int elat; logic [15:0] eword;
  } vec_t;
  vec_t tv [7];
  intipi_seq_if #(.ARCHBITSZ(16)) bus ();
  intipi_seq #(.ARCHBITSZ(16), .REQCOUNT(2), .INTDSTCOUNT(3), .INTCTRLADDR(0),
               .RETRYDELAY(8), .MAXRETRY(2)) dut (
    .clk_i(clk), .rst_i(rst), .rqst_i(rqst), .dst_i(dst), .done_o(done),
    .ok_o(ok), .busy_o(busy), .pi1(bus.master));
  always #5 clk = ~clk;
  // slave model: replies from rep[] in the cycle after each acceptance
  assign bus.pi1_data_i = (n_acc > base && n_acc - base <= 8) ? rep[n_acc - base - 1] : 16'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.pi1_op_o == 2'b11 && bus.pi1_rdy_i) begin
      if (n_acc < 64) begin
        acc_t[n_acc] <= cyc;
        acc_d[n_acc] <= bus.pi1_data_o;
      end
      n_acc <= n_acc + 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (done == 2'b00 && n < 100);
  endtask
  task automatic run_vec(input int i, input vec_t v);
    int n;
    base = n_acc;
    rep[0] = v.r0; rep[1] = v.r1; rep[2] = v.r2;
    dst = v.dst;
    rqst = v.rq;
    if (v.stall > 0) bus.pi1_rdy_i = 1'b0;
    n = 1;
    for (int k = 0; k < v.stall; k++) begin @(negedge clk); n++; end
    if (v.stall > 0) begin
      chk($sformatf("v%0d stall op", i), bus.pi1_op_o, 2'b11);
      chk($sformatf("v%0d stall data", i), bus.pi1_data_o, v.eword);
      bus.pi1_rdy_i = 1'b1;
    end
    do begin @(negedge clk); n++; end while (done == 2'b00 && n < 80);
    chk($sformatf("v%0d done", i), done, v.edone);
    chk($sformatf("v%0d ok", i), ok, v.eok);
    chk($sformatf("v%0d latency", i), n, v.elat);
    chk($sformatf("v%0d issues", i), n_acc - base, v.eiss);
    chk($sformatf("v%0d word", i), acc_d[base % 64], v.eword);
    for (int k = 1; k < v.eiss; k++)
      chk($sformatf("v%0d gap%0d", i, k), acc_t[(base + k) % 64] - acc_t[(base + k - 1) % 64], 10);
    rqst = 2'b00;
    @(negedge clk);
    chk($sformatf("v%0d pulse end", i), done, 2'b00);
    chk($sformatf("v%0d ok hold", i), ok, v.eok);
    @(negedge clk);
  endtask
  initial begin
    tv[0] = '{2'b01, 4'b0001, 16'h0001, 16'h0000, 16'h0000, 0, 2'b01, 1'b1, 1, 4, 16'h0005};
    tv[1] = '{2'b01, 4'b0001, 16'hFFFE, 16'hFFFE, 16'h0001, 0, 2'b01, 1'b1, 3, 24, 16'h0005};
    tv[2] = '{2'b01, 4'b0001, 16'hFFFE, 16'hFFFE, 16'hFFFE, 0, 2'b01, 1'b0, 3, 24, 16'h0005};
    tv[3] = '{2'b01, 4'b0011, 16'hFFFF, 16'h0000, 16'h0000, 0, 2'b01, 1'b0, 1, 4, 16'h000D};
    tv[4] = '{2'b10, 4'b1000, 16'h0002, 16'h0000, 16'h0000, 3, 2'b10, 1'b1, 1, 6, 16'h0009};
    tv[5] = '{2'b01, 4'b0000, 16'h0005, 16'h0000, 16'h0000, 0, 2'b01, 1'b0, 1, 4, 16'h0001};
    tv[6] = '{2'b10, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 2'b10, 1'b1, 1, 4, 16'h0001};
    bus.pi1_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst op", bus.pi1_op_o, 2'b00);
    chk("rst data", bus.pi1_data_o, 16'h0);
    chk("rst done", done, 2'b00);
    chk("rst ok", ok, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("sel", bus.pi1_sel_o, 2'b11);
    chk("addr", bus.pi1_addr_o, 15'h0);
    for (int i = 0; i < 7; i++) run_vec(i, tv[i]);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    base = n_acc;
    rep[0] = 16'h0001; rep[1] = 16'h0000; rep[2] = 16'h0001;
    dst = 4'b0001;
    rqst = 2'b11;
    wait_done(c);
    chk("rr first", done, 2'b01);
    rqst = 2'b10;
    @(negedge clk);
    rqst = 2'b11;
    wait_done(c);
    chk("rr second", done, 2'b10);
    chk("rr second ok", ok, 1'b1);
    rqst = 2'b01;
    wait_done(c);
    chk("rr third", done, 2'b01);
    chk("rr issues", n_acc - base, 3);
    rqst = 2'b00;
    repeat (2) @(negedge clk);
    base = n_acc;
    rep[0] = 16'hFFFE; rep[1] = 16'hFFFE; rep[2] = 16'h0001;
    dst = 4'b0001;
    rqst = 2'b01;
    c = 0;
    while (n_acc - base < 1 && c < 40) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    chk("wait busy", busy, 1'b1);
    chk("wait op", bus.pi1_op_o, 2'b00);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("midrst op", bus.pi1_op_o, 2'b00);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 2'b00);
    chk("midrst data", bus.pi1_data_o, 16'h0);
    base = n_acc;
    wait_done(c);
    chk("regrant done", done, 2'b01);
    chk("regrant ok", ok, 1'b1);
    chk("regrant issues", n_acc - base, 3);
    rqst = 2'b00;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
